instr_fsm: RTL and testbench
============================

INSTR_FSM -- requirements
Module: instr_fsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, synchronous, active-high.
REQ-004 Port s, input, 1, start request, sampled only in WAIT.
REQ-005 Port load, input, 1, instruction-register load enable.
REQ-006 Port in, input, 16, instruction word.
REQ-007 Port w, output, 1, idle/ready flag.
REQ-008 Ports readnum and writenum, output, 3 each, register-file read and write indices.
REQ-009 Port vsel, output, 2, write-back select: 11 mdata, 10 sximm8, 01 PC+1, 00 datapath_out.
REQ-010 Ports loada, loadb, loadc, loads, write, asel, output, 1 each, datapath strobes and selects; asel=1 forces ALU A to zero.
REQ-011 Ports bsel, shift and ALUop, output, 2 each; bsel 00 selects the shifter and 01 selects sximm5.
REQ-012 Ports sximm5 and sximm8, output, 16 each, sign-extended immediates.

Function
REQ-013 The IR (16b) SHALL capture in on a clk edge with load=1, only while in WAIT; load is ignored in every other state.
REQ-014 Decode fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-015 sximm8 SHALL be {8{IR[7]},IR[7:0]} and sximm5 SHALL be {11{IR[4]},IR[4:0]}, both continuous.
REQ-016 States SHALL be WAIT, DECODE, GET_A, GET_B, ALU, WR_REG and WR_IMM.
REQ-017 All outputs SHALL be Moore (state+IR), and every unlisted strobe SHALL be 0 in every state.
REQ-018 WAIT: w=1; if s=1, next state is DECODE; otherwise stay.
REQ-019 DECODE transitions:
- MOV imm (110,10) -> WR_IMM.
- MOV reg (110,00) -> GET_B.
- MVN (101,11) -> GET_B.
- ADD/CMP/AND (101,00/01/10) -> GET_A.
- Any other encoding -> WAIT, with no strobes.
REQ-020 WR_IMM: write=1, vsel=10, writenum=Rn; next state WAIT.
REQ-021 GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-022 GET_B: readnum=Rm, loadb=1, shift=sh; next state ALU.
REQ-023 ALU: bsel=00 and shift=sh, with per-instruction outputs:
- MOV reg: ALUop=00, asel=1.
- Opcode 101: ALUop=op, asel=0.
- All except CMP: loadc=1, next state WR_REG.
- CMP: loads=1, loadc=0, next state WAIT.
REQ-024 WR_REG: write=1, vsel=00, writenum=Rd; next state WAIT.
REQ-025 Latency from the s-sampling edge back to w=1 SHALL be:
- MOV imm: 2 cycles.
- MOV reg / MVN: 4 cycles.
- CMP: 4 cycles.
- ADD / AND: 5 cycles.
REQ-026 If s is held high, a new instruction SHALL start on the first WAIT cycle, with exactly one WAIT cycle between instructions.

Reset
REQ-027 On a reset edge: state=WAIT and IR=0; reset has priority over s and load.
REQ-028 write, loada, loadb, loadc and loads SHALL be forced to 0 in any cycle where reset=1, including mid-instruction.
REQ-029 After reset: w=1, sximm5=sximm8=0, and all other outputs are 0.

Structure
REQ-030 The state encodings, opcode/op constants and vsel/bsel codes SHALL live in a shared package used by the datapath bench.
REQ-031 Field extraction and sign extension SHALL be one combinational sub-module, instr_dec; the FSM and IR stay in instr_fsm.

Verification
REQ-032 MOV R0,#7 (in=D007, load=1 then s=1): DECODE, then WR_IMM with write=1, writenum=0, vsel=10, sximm8=0007; w=1 two edges after s.
REQ-033 MOV R1,#-2 (in=D1FE): sximm8=FFFE, writenum=1 in WR_IMM.
REQ-034 ADD R2,R1,R0 LSL#1 (in=A148):
- GET_A: readnum=1, loada=1.
- GET_B: readnum=0, loadb=1, shift=01.
- ALU: ALUop=00, asel=0, loadc=1.
- WR_REG: writenum=2, vsel=00, write=1.
- w returns after 5 edges.
REQ-035 CMP R1,R0 (in=A900): loads=1 in ALU, write never 1, back in WAIT after 4 edges.
REQ-036 Reset pulsed during GET_B of ADD: write=0 throughout, next state WAIT, IR=0000, w=1.
REQ-037 in=0000 -> DECODE then WAIT with no strobes; in=FFFF with load=1 during GET_A leaves the IR unchanged.

Source files
------------

// File: rtl/instr_fsm_pkg.sv
// Shared encodings for the instruction FSM: states, opcode/op fields, datapath select codes,
// and the per-state control word decode.
package instr_fsm_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StAlu,
    StWrReg,
    StWrImm
  } state_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpMovImm = 2'b10;
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpCmp    = 2'b01;
  localparam logic [1:0] OpAnd    = 2'b10;
  localparam logic [1:0] OpMvn    = 2'b11;

  localparam logic [1:0] VselMdata  = 2'b11;
  localparam logic [1:0] VselSximm8 = 2'b10;
  localparam logic [1:0] VselPc     = 2'b01;
  localparam logic [1:0] VselDout   = 2'b00;

  localparam logic [1:0] BselShift  = 2'b00;
  localparam logic [1:0] BselSximm5 = 2'b01;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic [1:0] bsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state, given the decoded instruction fields.
  function automatic ctrl_t state_ctrl(state_e st, logic [2:0] opcode, logic [1:0] op,
                                       logic [2:0] rn, logic [2:0] rd, logic [1:0] sh,
                                       logic [2:0] rm);
    ctrl_t c;
    c = '0;
    case (st)
      StWait: c.w = 1'b1;
      StGetA: begin
        c.readnum = rn;
        c.loada   = 1'b1;
      end
      StGetB: begin
        c.readnum = rm;
        c.loadb   = 1'b1;
        c.shift   = sh;
      end
      StAlu: begin
        c.bsel  = BselShift;
        c.shift = sh;
        if (opcode == OpcMov) begin
          c.alu_op = OpAdd;
          c.asel   = 1'b1;
        end else begin
          c.alu_op = op;
        end
        if (opcode == OpcAlu && op == OpCmp) c.loads = 1'b1;
        else c.loadc = 1'b1;
      end
      StWrReg: begin
        c.write    = 1'b1;
        c.vsel     = VselDout;
        c.writenum = rd;
      end
      StWrImm: begin
        c.write    = 1'b1;
        c.vsel     = VselSximm8;
        c.writenum = rn;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_fsm_dec.sv
// Instruction field extraction and immediate sign extension (purely combinational).
module instr_dec
  import instr_fsm_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/instr_fsm.sv
// Instruction register plus the multi-cycle control FSM driving the register file and datapath.
module instr_fsm
  import instr_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic [1:0]  bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  ctrl_t       ctrl_q;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  instr_dec u_dec (
    .ir     (ir_q),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StWait:   if (s) state_d = StDecode;
      StDecode: begin
        state_d = StWait;
        if (opcode == OpcMov && op == OpMovImm)      state_d = StWrImm;
        else if (opcode == OpcMov && op == OpMovReg) state_d = StGetB;
        else if (opcode == OpcAlu && op == OpMvn)    state_d = StGetB;
        else if (opcode == OpcAlu)                   state_d = StGetA;
      end
      StGetA:   state_d = StGetB;
      StGetB:   state_d = StAlu;
      StAlu:    state_d = (opcode == OpcAlu && op == OpCmp) ? StWait : StWrReg;
      default:  state_d = StWait;
    endcase
  end

  // IR only changes in WAIT, and neither WAIT nor DECODE outputs depend on it, so the control
  // word for the next state can be decoded from the current IR fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= '0;
      ctrl_q  <= state_ctrl(StWait, opcode, op, rn, rd, sh, rm);
    end else begin
      state_q <= state_d;
      if (state_q == StWait && load) ir_q <= in;
      ctrl_q  <= state_ctrl(state_d, opcode, op, rn, rd, sh, rm);
    end
  end

  // Strobes are killed combinationally so a reset cycle never commits a register write.
  assign w        = ctrl_q.w;
  assign readnum  = ctrl_q.readnum;
  assign writenum = ctrl_q.writenum;
  assign vsel     = ctrl_q.vsel;
  assign loada    = ctrl_q.loada & ~reset;
  assign loadb    = ctrl_q.loadb & ~reset;
  assign loadc    = ctrl_q.loadc & ~reset;
  assign loads    = ctrl_q.loads & ~reset;
  assign write    = ctrl_q.write & ~reset;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign shift    = ctrl_q.shift;
  assign ALUop    = ctrl_q.alu_op;

endmodule

// File: tb/tb_instr_fsm.sv
// Self-checking bench for instr_fsm: directed table, reset/back-to-back sequences and random
// instructions compared cycle by cycle against a micro-op trace model.
module tb_instr_fsm;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, loada, loadb, loadc, loads, write, asel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, bsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm5   (sximm5),
    .sximm8   (sximm8)
  );

  typedef logic [52:0] vec_t;
  vec_t actual;
  assign actual = {w, readnum, writenum, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                   shift, ALUop, sximm5, sximm8};

  typedef struct {
    logic [15:0] ir;
    int          lat;
    logic [15:0] x8;
    logic [15:0] x5;
    string       name;
  } vector_t;

  vec_t trace[$];

  function automatic logic [15:0] sext(int val, int bits);
    if (val >= (1 << (bits - 1))) val -= (1 << bits);
    return 16'(val);
  endfunction

  // Argument order: w, readnum, writenum, vsel, loada, loadb, loadc, loads, write, asel, bsel,
  // shift, ALUop; immediates come from the instruction word.
  function automatic vec_t mk(logic [15:0] ir, int wv, int rdn, int wrn, int vs, int la, int lb,
                              int lc, int ls, int wr, int as, int bs, int shf, int alu);
    return {1'(wv), 3'(rdn), 3'(wrn), 2'(vs), 1'(la), 1'(lb), 1'(lc), 1'(ls), 1'(wr), 1'(as),
            2'(bs), 2'(shf), 2'(alu), sext(int'(ir[4:0]), 5), sext(int'(ir[7:0]), 8)};
  endfunction

  // Expected outputs for each cycle after the s-sampling edge, one entry per micro-op.
  task automatic build_trace(input logic [15:0] ir);
    int opc, op, rn, rd, sh, rm;
    bit mov, alu, movimm, movreg, mvn, cmp, twoop;
    opc = int'(ir[15:13]); op = int'(ir[12:11]); rn = int'(ir[10:8]);
    rd = int'(ir[7:5]); sh = int'(ir[4:3]); rm = int'(ir[2:0]);
    mov = (opc == 6); alu = (opc == 5);
    movimm = mov && op == 2; movreg = mov && op == 0;
    mvn = alu && op == 3; cmp = alu && op == 1; twoop = alu && op != 3;
    trace.delete();
    trace.push_back(mk(ir, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (movimm) begin
      trace.push_back(mk(ir, 0, 0, rn, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    end else if (movreg || mvn || twoop) begin
      if (twoop) trace.push_back(mk(ir, 0, rn, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      trace.push_back(mk(ir, 0, rm, 0, 0, 0, 1, 0, 0, 0, 0, 0, sh, 0));
      trace.push_back(mk(ir, 0, 0, 0, 0, 0, 0, int'(!cmp), int'(cmp), 0, int'(movreg), 0, sh,
                         movreg ? 0 : op));
      if (!cmp) trace.push_back(mk(ir, 0, 0, rd, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input vec_t exp);
    checks++;
    if (actual !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, actual, exp);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Reset with s/load asserted to show reset wins; outputs checked while reset is still high.
  task automatic do_reset(input bit do_check);
    reset = 1'b1; s = 1'b1; load = 1'b1; in = 16'hFFFF;
    tick;
    tick;
    if (do_check) check_vec("reset_state", mk(16'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (w !== 1'b1 && t < 20) begin
      tick;
      t++;
    end
    check_int(name, int'(w === 1'b1), 1);
  endtask

  task automatic run_instr(input logic [15:0] ir, input string name, input int lat_in,
                           input logic [15:0] x8, input logic [15:0] x5, input bit use_tab,
                           input bit busy_rand);
    int meas, t, exp_lat;
    in = ir; load = 1'b1; s = 1'b0;
    tick;
    load = 1'b0;
    if (use_tab) check_int({name, "_imm"}, {sximm8, sximm5}, {x8, x5});
    build_trace(ir);
    exp_lat = use_tab ? lat_in : trace.size();
    s = 1'b1;
    tick;
    s = 1'b0;
    meas = -1;
    foreach (trace[k]) begin
      if (meas < 0 && w === 1'b1) meas = k;
      check_vec($sformatf("%s_c%0d", name, k), trace[k]);
      if (busy_rand) begin
        load = 1'($urandom); in = 16'($urandom); s = 1'($urandom);
      end
      tick;
    end
    load = 1'b0; s = 1'b0;
    if (meas < 0) begin
      t = trace.size();
      while (w !== 1'b1 && t < 12) begin
        tick;
        t++;
      end
      meas = (w === 1'b1) ? t : -1;
    end
    check_int({name, "_lat"}, meas, exp_lat);
    check_vec({name, "_idle"}, mk(ir, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (w !== 1'b1) do_reset(1'b0);
  endtask

  vector_t tab[$];
  logic [15:0] rir;

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    tab = '{
      '{16'hD007, 2, 16'h0007, 16'h0007, "mov_r0_7"},
      '{16'hD1FE, 2, 16'hFFFE, 16'hFFFE, "mov_r1_m2"},
      '{16'hA148, 5, 16'h0048, 16'h0008, "add_r2"},
      '{16'hA900, 4, 16'h0000, 16'h0000, "cmp_r1_r0"},
      '{16'hC0A3, 4, 16'hFFA3, 16'h0003, "mov_reg"},
      '{16'hB871, 4, 16'h0071, 16'hFFF1, "mvn"},
      '{16'hB2F4, 5, 16'hFFF4, 16'hFFF4, "and"},
      '{16'h0000, 1, 16'h0000, 16'h0000, "undef_0000"}
    };

    do_reset(1'b1);

    foreach (tab[i]) run_instr(tab[i].ir, tab[i].name, tab[i].lat, tab[i].x8, tab[i].x5, 1'b1,
                               1'b0);

    // Reset landing in GET_B of an ADD.
    in = 16'hA148; load = 1'b1; tick; load = 1'b0; s = 1'b1; tick; s = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    check_vec("rst_in_getb", mk(16'hA148, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick;
    check_vec("rst_after_getb", mk(16'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    tick;
    check_vec("idle_after_rst", mk(16'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during WR_REG must suppress the write strobe in the same cycle.
    in = 16'hA148; load = 1'b1; tick; load = 1'b0; s = 1'b1; tick; s = 1'b0;
    tick;
    tick;
    tick;
    tick;
    reset = 1'b1;
    #1;
    check_vec("rst_in_wrreg", mk(16'hA148, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    check_vec("rst_after_wrreg", mk(16'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // load with FFFF during GET_A must not disturb the IR.
    in = 16'hA148; load = 1'b1; tick; load = 1'b0; s = 1'b1; tick; s = 1'b0;
    tick;
    load = 1'b1; in = 16'hFFFF;
    tick;
    load = 1'b0;
    wait_idle("ir_hold_idle");
    check_int("ir_hold_imm", {sximm8, sximm5}, {16'h0048, 16'h0008});

    // s held high: one WAIT cycle, then the next instruction starts.
    in = 16'hA148; load = 1'b1; tick; load = 1'b0; s = 1'b1;
    tick;
    build_trace(16'hA148);
    for (int k = 0; k < 5; k++) tick;
    check_vec("b2b_wait", mk(16'hA148, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick;
    check_vec("b2b_decode", trace[0]);
    tick;
    check_vec("b2b_geta", trace[1]);
    s = 1'b0;
    wait_idle("b2b_done");

    // Random instructions, mostly drawn from the legal encodings, with noise on s/load/in
    // while busy.
    for (int n = 0; n < 40; n++) begin
      rir = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rir[15:11] = 5'b11010;
        1: rir[15:11] = 5'b11000;
        2: rir[15:11] = 5'b10100;
        3: rir[15:11] = 5'b10101;
        4: rir[15:11] = 5'b10110;
        5: rir[15:11] = 5'b10111;
        default: ;
      endcase
      run_instr(rir, $sformatf("rnd%0d_%h", n, rir), 0, 16'h0, 16'h0, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
